vga_flag_renderer: RTL and testbench
====================================

VGA_FLAG_RENDERER -- requirements
Module: vga_flag_renderer

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, horizontal sync pulse length in pixels.
REQ-002 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 SHALL have parameter V_SYNC, default 2, vertical sync length in lines.
REQ-005 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-006 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-007 SHALL have parameter FRAMES_PER_FLAG, default 60, frames shown per flag in auto mode.
REQ-008 VGA_CLK  input  1  pixel clock; one clock; all logic on its rising edge.
REQ-009 RESET  input  1  synchronous, active-high reset.
REQ-010 H_COUNT  input  10  horizontal counter from the timing generator; 0 = start of sync pulse.
REQ-011 V_COUNT  input  10  vertical counter from the timing generator; 0 = start of vertical sync.
REQ-012 HS_IN  input  1  horizontal sync from the timing generator, active low.
REQ-013 VS_IN  input  1  vertical sync from the timing generator, active low.
REQ-014 FLAG_SEL  input  2  manual flag select.
REQ-015 AUTO_CYCLE  input  1  1 = cycle flags automatically.
REQ-016 VGA_R, VGA_G, VGA_B  output  4 each  registered colour outputs.
REQ-017 VGA_HS, VGA_VS  output  1 each  registered, delay-matched sync outputs.

Function
REQ-018 Visible window SHALL be half-open: H_COUNT in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE), V_COUNT in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE); defaults give x in [144,784), y in [35,515).
REQ-019 Stage 1 SHALL register active flag and local coordinates x = H_COUNT-144, y = V_COUNT-35; stage 2 SHALL register colour; colour latency SHALL be exactly 2 cycles.
REQ-020 HS_IN and VS_IN SHALL pass through a 2-stage delay, so sync and colour stay aligned.
REQ-021 Outside the visible window all colour outputs SHALL be 0.
REQ-022 Flag 0 SHALL be solid blue: B=8, R=G=0.
REQ-023 Flag 1 SHALL be four horizontal bands: y 0-119 red, 120-239 green, 240-359 blue, 360-479 white (R=G=B=8).
REQ-024 Flag 2 SHALL be three bands: y 0-159 green, 160-319 yellow (R=G=8), 320-479 red.
REQ-025 Flag 3 SHALL be all black.
REQ-026 Band boundaries SHALL be derived from V_ACTIVE by constant division (/4, /3), with no run-time divider.
REQ-027 Frame start SHALL be the cycle in which H_COUNT==0 and V_COUNT==0; the displayed flag register SHALL update only at frame start, so no frame ever mixes two flags.
REQ-028 Control FSM SHALL have states MANUAL and AUTO; at each frame start it SHALL sample AUTO_CYCLE and enter AUTO if 1, MANUAL if 0.
REQ-029 In MANUAL, at frame start, flag SHALL load FLAG_SEL, and the frame counter SHALL be cleared to 0.
REQ-030 In AUTO, at frame start, frame counter SHALL increment; when it equals FRAMES_PER_FLAG-1 it SHALL wrap to 0 and flag SHALL advance 0->1->2->0, skipping 3.
REQ-031 Entering AUTO with flag==3 SHALL force flag to 0 at that frame start.
REQ-032 Changes to FLAG_SEL or AUTO_CYCLE mid-frame SHALL have no visible effect until the next frame start.
REQ-033 Frame counter SHALL be wide enough for FRAMES_PER_FLAG-1, and SHALL never exceed it.

Reset
REQ-034 On RESET: colours 0, VGA_HS=1, VGA_VS=1, pipeline regs cleared (active=0), FSM=MANUAL, flag=0, frame counter=0.
REQ-035 RESET asserted mid-frame SHALL take effect on the next edge; after release, output SHALL be blank until the first valid pipeline data 2 cycles later, and flag SHALL stay 0 until the next frame start.

Structure
REQ-036 Timing constants (sync/porch/active values), colour level 8, flag codes and FSM state encoding SHALL live in shared package vga_pkg, which the timing generator also uses.
REQ-037 Band-to-colour mapping SHALL be one sub-module, vga_flag_palette (combinational: flag, y -> RGB), instantiated in stage 2.

Verification
REQ-038 Reset, then H=144,V=35 with MANUAL flag 0 -> after 2 cycles R=0,G=0,B=8; H=143 -> all 0.
REQ-039 Flag 1, y=119 vs y=120 (V=154/155) -> red then green; y=479 (V=514) white; V=515 -> black.
REQ-040 FLAG_SEL changed 0->2 at H=400,V=200 -> rest of frame stays blue; from next frame start, row y=0 green.
REQ-041 AUTO_CYCLE=1, FRAMES_PER_FLAG=3 -> flag sequence 0,0,0,1,1,1,2,2,2,0 across consecutive frames.
REQ-042 HS_IN low for H 0-95 -> VGA_HS low exactly 2 cycles later for 96 cycles; VGA_VS delay likewise 2 cycles.
REQ-043 RESET pulsed at H=500,V=300 with flag 2 in AUTO -> next cycle outputs 0, HS/VS=1; FSM=MANUAL, flag 0 thereafter.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour level, flag codes and control-state encoding.
// Used by the timing generator and by the flag renderer.
package vga_pkg;

  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;

  localparam logic [3:0] COLOUR_LEVEL = 4'd8;

  typedef enum logic [1:0] {
    FLAG_BLUE   = 2'd0,
    FLAG_BANDS4 = 2'd1,
    FLAG_BANDS3 = 2'd2,
    FLAG_BLACK  = 2'd3
  } flag_t;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Auto rotation visits the three coloured flags only; black is never chosen.
  function automatic flag_t next_auto_flag(input flag_t f);
    case (f)
      FLAG_BLUE:   next_auto_flag = FLAG_BANDS4;
      FLAG_BANDS4: next_auto_flag = FLAG_BANDS3;
      default:     next_auto_flag = FLAG_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/vga_flag_palette.sv
// Combinational band-to-colour map: selected flag plus visible line y gives RGB.
module vga_flag_palette
  import vga_pkg::*;
#(
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  flag_t      flag,
  input  logic [9:0] y,
  output rgb_t       rgb
);

  // Band edges are elaboration-time constants, so no divider is built.
  localparam logic [9:0] QUARTER_1 = 10'(V_ACTIVE / 4);
  localparam logic [9:0] QUARTER_2 = 10'((2 * V_ACTIVE) / 4);
  localparam logic [9:0] QUARTER_3 = 10'((3 * V_ACTIVE) / 4);
  localparam logic [9:0] THIRD_1   = 10'(V_ACTIVE / 3);
  localparam logic [9:0] THIRD_2   = 10'((2 * V_ACTIVE) / 3);

  always_comb begin
    rgb = '0;
    unique case (flag)
      FLAG_BLUE: begin
        rgb.b = COLOUR_LEVEL;
      end
      FLAG_BANDS4: begin
        if (y < QUARTER_1) begin
          rgb.r = COLOUR_LEVEL;
        end else if (y < QUARTER_2) begin
          rgb.g = COLOUR_LEVEL;
        end else if (y < QUARTER_3) begin
          rgb.b = COLOUR_LEVEL;
        end else begin
          rgb.r = COLOUR_LEVEL;
          rgb.g = COLOUR_LEVEL;
          rgb.b = COLOUR_LEVEL;
        end
      end
      FLAG_BANDS3: begin
        if (y < THIRD_1) begin
          rgb.g = COLOUR_LEVEL;
        end else if (y < THIRD_2) begin
          rgb.r = COLOUR_LEVEL;
          rgb.g = COLOUR_LEVEL;
        end else begin
          rgb.r = COLOUR_LEVEL;
        end
      end
      FLAG_BLACK: begin
        rgb = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_flag_renderer.sv
// Two-stage pixel pipeline painting one of four flags, with a frame-synchronous
// manual/auto flag selector and delay-matched sync outputs.
module vga_flag_renderer
  import vga_pkg::*;
#(
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BACK          = VGA_H_BACK,
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BACK          = VGA_V_BACK,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter int FRAMES_PER_FLAG = 60
) (
  input  logic       VGA_CLK,
  input  logic       RESET,
  input  logic [9:0] H_COUNT,
  input  logic [9:0] V_COUNT,
  input  logic       HS_IN,
  input  logic       VS_IN,
  input  logic [1:0] FLAG_SEL,
  input  logic       AUTO_CYCLE,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_SPAN  = 10'(H_ACTIVE);
  localparam logic [9:0] V_SPAN  = 10'(V_ACTIVE);

  localparam int FC_W = (FRAMES_PER_FLAG > 1) ? $clog2(FRAMES_PER_FLAG) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_FLAG - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  ctrl_state_t     state;
  flag_t           flag;
  logic [FC_W-1:0] frame_cnt;

  logic       frame_start;
  logic       in_window;
  logic       active_s1;
  logic [9:0] x_s1;
  logic [9:0] y_s1;
  logic       hs_s1;
  logic       vs_s1;
  logic       pixel_on;
  rgb_t       pal_rgb;

  assign frame_start = (H_COUNT == 10'd0) && (V_COUNT == 10'd0);
  assign in_window   = (H_COUNT >= H_START) && (H_COUNT < H_END) &&
                       (V_COUNT >= V_START) && (V_COUNT < V_END);

  // Flag and frame counter only move at frame start, so a frame never mixes flags.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state     <= ST_MANUAL;
      flag      <= FLAG_BLUE;
      frame_cnt <= '0;
    end else if (frame_start) begin
      if (AUTO_CYCLE) begin
        state <= ST_AUTO;
        if ((state == ST_MANUAL) && (flag == FLAG_BLACK)) begin
          flag      <= FLAG_BLUE;
          frame_cnt <= '0;
        end else if (frame_cnt == FC_LAST) begin
          flag      <= next_auto_flag(flag);
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + FC_ONE;
        end
      end else begin
        state     <= ST_MANUAL;
        flag      <= flag_t'(FLAG_SEL);
        frame_cnt <= '0;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      active_s1 <= 1'b0;
      x_s1      <= '0;
      y_s1      <= '0;
      hs_s1     <= 1'b1;
      vs_s1     <= 1'b1;
    end else begin
      active_s1 <= in_window;
      x_s1      <= H_COUNT - H_START;
      y_s1      <= V_COUNT - V_START;
      hs_s1     <= HS_IN;
      vs_s1     <= VS_IN;
    end
  end

  assign pixel_on = active_s1 && (x_s1 < H_SPAN) && (y_s1 < V_SPAN);

  vga_flag_palette #(
    .V_ACTIVE(V_ACTIVE)
  ) u_palette (
    .flag(flag),
    .y   (y_s1),
    .rgb (pal_rgb)
  );

  // Colour is gated by the stage-1 window flag; sync rides the same two stages.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_R  <= pixel_on ? pal_rgb.r : 4'd0;
      VGA_G  <= pixel_on ? pal_rgb.g : 4'd0;
      VGA_B  <= pixel_on ? pal_rgb.b : 4'd0;
      VGA_HS <= hs_s1;
      VGA_VS <= vs_s1;
    end
  end

endmodule

// File: tb/tb_vga_flag_renderer.sv
// Scoreboard bench for vga_flag_renderer: a frame-level reference model queues the
// expected pixel for every cycle and a monitor compares the DUT one cycle later.
module tb_vga_flag_renderer;

  localparam int FPF = 3;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    string      tag;
  } exp_t;

  logic       vga_clk;
  logic       reset;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hs_in;
  logic       vs_in;
  logic [1:0] flag_sel;
  logic       auto_cycle;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;

  exp_t sb[$];
  exp_t pending;
  int   m_flag;
  int   m_shown;
  int   n_cmp;
  int   n_err;

  vga_flag_renderer #(
    .FRAMES_PER_FLAG(FPF)
  ) dut (
    .VGA_CLK   (vga_clk),
    .RESET     (reset),
    .H_COUNT   (h_count),
    .V_COUNT   (v_count),
    .HS_IN     (hs_in),
    .VS_IN     (vs_in),
    .FLAG_SEL  (flag_sel),
    .AUTO_CYCLE(auto_cycle),
    .VGA_R     (vga_r),
    .VGA_G     (vga_g),
    .VGA_B     (vga_b),
    .VGA_HS    (vga_hs),
    .VGA_VS    (vga_vs)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.r = 4'd0; e.g = 4'd0; e.b = 4'd0;
    e.hs = 1'b1; e.vs = 1'b1;
    e.tag = tag;
    return e;
  endfunction

  // Picture as a viewer sees it: 640x480 window at (144,35), bands by fraction of height.
  function automatic exp_t make_exp(input int h, input int v, input bit hs, input bit vs,
                                    input int f, input string tag);
    exp_t e;
    int   y;
    int   band;
    e = blank(tag);
    e.hs = hs;
    e.vs = vs;
    if (h >= 144 && h < 784 && v >= 35 && v < 515) begin
      y = v - 35;
      case (f)
        0: e.b = 4'd8;
        1: begin
          band = (y * 4) / 480;
          case (band)
            0: e.r = 4'd8;
            1: e.g = 4'd8;
            2: e.b = 4'd8;
            default: begin e.r = 4'd8; e.g = 4'd8; e.b = 4'd8; end
          endcase
        end
        2: begin
          band = (y * 3) / 480;
          case (band)
            0: e.g = 4'd8;
            1: begin e.r = 4'd8; e.g = 4'd8; end
            default: e.r = 4'd8;
          endcase
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic applyStimulus(input int h, input int v, input bit hs, input bit vs,
                               input int sel, input bit au, input bit rst, input string tag);
    exp_t now_exp;
    @(negedge vga_clk);
    h_count    = h[9:0];
    v_count    = v[9:0];
    hs_in      = hs;
    vs_in      = vs;
    flag_sel   = sel[1:0];
    auto_cycle = au;
    reset      = rst;
    if (rst) begin
      m_flag  = 0;
      m_shown = 1;
    end else if (h == 0 && v == 0) begin
      if (!au) begin
        m_flag  = sel;
        m_shown = 1;
      end else if (m_flag == 3) begin
        m_flag  = 0;
        m_shown = 1;
      end else if (m_shown == FPF) begin
        m_flag  = (m_flag + 1) % 3;
        m_shown = 1;
      end else begin
        m_shown = m_shown + 1;
      end
    end
    now_exp = rst ? blank(tag) : pending;
    sb.push_back(now_exp);
    pending = rst ? blank(tag) : make_exp(h, v, hs, vs, m_flag, tag);
  endtask

  task automatic checkOutput(input exp_t e);
    n_cmp++;
    if (vga_r !== e.r || vga_g !== e.g || vga_b !== e.b || vga_hs !== e.hs || vga_vs !== e.vs) begin
      n_err++;
      $display("[TB] FAIL %s: got rgb=%h%h%h hs=%b vs=%b, want rgb=%h%h%h hs=%b vs=%b",
               e.tag, vga_r, vga_g, vga_b, vga_hs, vga_vs, e.r, e.g, e.b, e.hs, e.vs);
    end
  endtask

  always @(posedge vga_clk) begin
    #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    int  h;
    int  v;
    int  sel;
    bit  au;
    bit  rst;
    n_cmp   = 0;
    n_err   = 0;
    m_flag  = 0;
    m_shown = 1;
    pending = blank("start");
    h_count = '0; v_count = 10'd10; hs_in = 1'b1; vs_in = 1'b1;
    flag_sel = '0; auto_cycle = 1'b0; reset = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(10, 10, 1, 1, 0, 0, 1, "reset");

    applyStimulus(0, 0, 1, 1, 0, 0, 0, "fstart_blue");
    applyStimulus(144, 35, 1, 1, 0, 0, 0, "blue_first_px");
    applyStimulus(143, 35, 1, 1, 0, 0, 0, "left_of_window");
    applyStimulus(783, 514, 1, 1, 0, 0, 0, "blue_last_px");
    applyStimulus(784, 35, 1, 1, 0, 0, 0, "right_of_window");
    applyStimulus(144, 34, 1, 1, 0, 0, 0, "above_window");

    applyStimulus(0, 0, 1, 1, 1, 0, 0, "fstart_bands4");
    applyStimulus(200, 154, 1, 1, 1, 0, 0, "bands4_y119");
    applyStimulus(200, 155, 1, 1, 1, 0, 0, "bands4_y120");
    applyStimulus(200, 274, 1, 1, 1, 0, 0, "bands4_y239");
    applyStimulus(200, 275, 1, 1, 1, 0, 0, "bands4_y240");
    applyStimulus(200, 514, 1, 1, 1, 0, 0, "bands4_y479");
    applyStimulus(200, 515, 1, 1, 1, 0, 0, "below_window");

    applyStimulus(0, 0, 1, 1, 0, 0, 0, "fstart_blue2");
    applyStimulus(400, 200, 1, 1, 2, 0, 0, "sel_change_mid");
    applyStimulus(401, 200, 1, 1, 2, 0, 0, "mid_frame_blue");
    applyStimulus(500, 400, 1, 1, 2, 0, 0, "mid_frame_blue2");
    applyStimulus(0, 0, 1, 1, 2, 0, 0, "fstart_bands3");
    applyStimulus(144, 35, 1, 1, 2, 0, 0, "bands3_row0");
    applyStimulus(300, 195, 1, 1, 2, 0, 0, "bands3_y160");
    applyStimulus(300, 355, 1, 1, 2, 0, 0, "bands3_y320");

    applyStimulus(0, 0, 1, 1, 3, 0, 0, "fstart_black");
    applyStimulus(300, 100, 1, 1, 3, 0, 0, "black_px");
    applyStimulus(0, 0, 1, 1, 3, 1, 0, "enter_auto_from_black");
    applyStimulus(300, 100, 1, 1, 3, 1, 0, "auto_forced_blue");

    applyStimulus(0, 0, 1, 1, 0, 0, 0, "fstart_manual0");
    applyStimulus(300, 100, 1, 1, 0, 0, 0, "auto_seq_f0");
    for (int f = 1; f < 16; f++) begin
      applyStimulus(0, 0, 1, 1, 3, 1, 0, "auto_fstart");
      applyStimulus(300, 100, 1, 1, 3, 1, 0, $sformatf("auto_seq_f%0d", f));
    end
    applyStimulus(500, 300, 1, 1, 3, 1, 0, "auto_flag2_px");
    applyStimulus(500, 300, 0, 0, 3, 1, 1, "reset_mid_frame");
    for (int i = 0; i < 4; i++) applyStimulus(500, 300, 1, 1, 3, 1, 0, "after_reset_blue");

    for (int i = 0; i < 100; i++) applyStimulus(i, 5, (i >= 96), 1, 0, 0, 0, "hsync_delay");
    for (int i = 0; i < 6; i++) applyStimulus(50, 700, 1, (i < 2) ? 1'b1 : 1'b0, 0, 0, 0, "vsync_delay");

    sel = 0;
    au  = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        h = 0; v = 0;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) au = !au;
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(h, v, (h >= 96), (v >= 2), sel, au, rst, "random");
    end

    for (int i = 0; i < 3; i++) applyStimulus(10, 10, 1, 1, 0, 0, 0, "drain");
    @(posedge vga_clk);
    @(posedge vga_clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
